// File: rtl/mem_loader.sv
// Byte-stream to 32-bit RAM write-port loader: packs four bytes little-endian per word.
// Optional running checksum of written words when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_written,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  // Largest load that fits the RAM without the address wrapping.
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(64'(1) << ADDR_W);

  state_e              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    ww_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         word_q;
  logic [1:0]          idx_q;
  logic [LEN_W-1:0]    len_clamped;
  logic [LEN_W-1:0]    ww_next;

  assign len_clamped = (len_words > MaxLen) ? MaxLen : len_words;
  assign ww_next     = ww_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      ww_q    <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= len_clamped;
            addr_q  <= '0;
            idx_q   <= '0;
            ww_q    <= '0;
            state_q <= (len_clamped == '0) ? StDone : StRecv;
          end
        end
        StRecv: begin
          if (s_valid) begin
            word_q[{idx_q, 3'b000} +: 8] <= s_data;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) state_q <= StWrite;
          end
        end
        StWrite: begin
          addr_q  <= addr_q + ADDR_W'(1);
          ww_q    <= ww_next;
          state_q <= (ww_next == len_q) ? StDone : StRecv;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake and strobes decode from the state register only.
  assign s_ready       = (state_q == StRecv);
  assign ena           = (state_q == StWrite);
  assign wea           = ena;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign addra         = addr_q;
  assign dina          = word_q;
  assign words_written = ww_q;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (state_q == StIdle && start) begin
      csum_q <= '0;
    end else if (state_q == StWrite) begin
      csum_q <= csum_q + word_q;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader: byte feeder, write monitor, hand-computed vectors.
module tb_mem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  len_words;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        ena;
  logic        wea;
  logic [8:0]  addra;
  logic [31:0] dina;
  logic        busy;
  logic        done;
  logic [9:0]  words_written;
  logic [31:0] checksum;

  mem_loader #(.ADDR_W(9), .LEN_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len_words     (len_words),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .ena           (ena),
    .wea           (wea),
    .addra         (addra),
    .dina          (dina),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .checksum      (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          start_cyc;
  int          done_cyc;
  int          done_cnt;
  int          busy_cnt;
  int          bad_ready;
  int          wea_bad;
  int          acc_cnt;
  bit          toggle_mode;
  bit          tog;
  logic [7:0]  byte_q[$];
  logic [8:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Byte source: presents the queue head; a byte shown while s_ready is high is taken next edge.
  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    tog     = 1'b0;
    forever begin
      @(negedge clk);
      tog = ~tog;
      if (byte_q.size() != 0 && (!toggle_mode || tog)) begin
        s_valid = 1'b1;
        s_data  = byte_q[0];
        if (s_ready) begin
          void'(byte_q.pop_front());
          acc_cnt++;
        end
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ena) begin
        wr_addr.push_back(addra);
        wr_data.push_back(dina);
      end
      if (wea !== ena) wea_bad++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (s_ready && (ena || done)) bad_ready++;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt  = 0;
    busy_cnt  = 0;
    bad_ready = 0;
    wea_bad   = 0;
    acc_cnt   = 0;
  endtask

  task automatic start_load(input logic [9:0] len);
    @(posedge clk);
    #1;
    start     = 1'b1;
    len_words = len;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    len_words = 10'h3ff;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] exp_sum;
  logic [31:0] exp_word;
  int          errs;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    toggle_mode = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    len_words   = '0;
    clear_log();
    idle_cycles(2);
    check_eq("rst_outputs", {26'd0, s_ready, ena, wea, busy, done, 1'b0}, 32'h0);
    check_eq("rst_addra", {23'd0, addra}, 32'h0);
    check_eq("rst_dina", dina, 32'h0);
    check_eq("rst_ww", {22'd0, words_written}, 32'h0);
    check_eq("rst_csum", checksum, 32'h0);
    rst = 1'b0;
    idle_cycles(1);

    // Two words, valid held high.
    clear_log();
    for (int i = 1; i <= 8; i++) byte_q.push_back(8'(i));
    start_load(10'd2);
    wait_done(40);
    idle_cycles(2);
`ifdef MEM_LOADER_CHECKSUM_EN
    exp_sum = 32'h0C0A0806;
`else
    exp_sum = 32'h0;
`endif
    check_eq("two_done_cnt", done_cnt, 1);
    check_eq("two_done_lat", done_cyc - start_cyc, 11);
    check_eq("two_wr_cnt", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check_eq("two_addr0", {23'd0, wr_addr[0]}, 32'd0);
      check_eq("two_data0", wr_data[0], 32'h04030201);
      check_eq("two_addr1", {23'd0, wr_addr[1]}, 32'd1);
      check_eq("two_data1", wr_data[1], 32'h08070605);
    end
    check_eq("two_ww", {22'd0, words_written}, 32'd2);
    check_eq("two_csum", checksum, exp_sum);
    check_eq("two_busy_cyc", busy_cnt, 11);
    check_eq("two_wea", wea_bad, 0);

    // Zero-length load.
    clear_log();
    start_load(10'd0);
    wait_done(10);
    idle_cycles(2);
    check_eq("zero_wr_cnt", wr_addr.size(), 0);
    check_eq("zero_busy_cyc", busy_cnt, 1);
    check_eq("zero_done_lat", done_cyc - start_cyc, 1);
    check_eq("zero_ww", {22'd0, words_written}, 32'd0);
    check_eq("zero_csum", checksum, 32'h0);

    // One word with s_valid toggling.
    clear_log();
    toggle_mode = 1'b1;
    byte_q.push_back(8'hAA);
    byte_q.push_back(8'hBB);
    byte_q.push_back(8'hCC);
    byte_q.push_back(8'hDD);
    start_load(10'd1);
    wait_done(40);
    idle_cycles(2);
    toggle_mode = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
    exp_sum = 32'hDDCCBBAA;
`else
    exp_sum = 32'h0;
`endif
    check_eq("tog_wr_cnt", wr_addr.size(), 1);
    if (wr_data.size() == 1) check_eq("tog_data", wr_data[0], 32'hDDCCBBAA);
    check_eq("tog_ready_bad", bad_ready, 0);
    check_eq("tog_ww", {22'd0, words_written}, 32'd1);
    check_eq("tog_csum", checksum, exp_sum);

    // Oversized length clamps to the RAM depth.
    clear_log();
    for (int i = 0; i < 2048; i++) byte_q.push_back(8'(i));
    start_load(10'd700);
    wait_done(3000);
    idle_cycles(2);
    check_eq("big_done_cnt", done_cnt, 1);
    check_eq("big_wr_cnt", wr_addr.size(), 512);
    errs = 0;
    for (int j = 0; j < 512; j++) begin
      exp_word = {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
      if (j >= wr_addr.size()) errs++;
      else if (wr_addr[j] !== 9'(j) || wr_data[j] !== exp_word) errs++;
    end
    check_eq("big_order", errs, 0);
    check_eq("big_ww", {22'd0, words_written}, 32'd512);
    byte_q.delete();

    // Reset two bytes into a word.
    clear_log();
    byte_q.push_back(8'h11);
    byte_q.push_back(8'h22);
    byte_q.push_back(8'h33);
    byte_q.push_back(8'h44);
    start_load(10'd1);
    begin
      int n;
      n = 0;
      while (acc_cnt < 2 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("mid_two_bytes", acc_cnt, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_outputs", {27'd0, s_ready, ena, wea, busy, done}, 32'h0);
    check_eq("mid_rst_dina", dina, 32'h0);
    check_eq("mid_rst_ww", {22'd0, words_written}, 32'h0);
    rst = 1'b0;
    byte_q.delete();
    idle_cycles(2);
    check_eq("mid_no_write", wr_addr.size(), 0);
    check_eq("mid_no_done", done_cnt, 0);
    clear_log();
    byte_q.push_back(8'h55);
    byte_q.push_back(8'h66);
    byte_q.push_back(8'h77);
    byte_q.push_back(8'h88);
    start_load(10'd1);
    wait_done(40);
    idle_cycles(2);
    check_eq("mid_new_cnt", wr_addr.size(), 1);
    if (wr_data.size() == 1) check_eq("mid_new_data", wr_data[0], 32'h88776655);

    // Start during RECV is ignored.
    clear_log();
    byte_q.push_back(8'hDE);
    byte_q.push_back(8'hAD);
    byte_q.push_back(8'hBE);
    byte_q.push_back(8'hEF);
    start_load(10'd1);
    start_load(10'd5);
    wait_done(40);
    idle_cycles(10);
    check_eq("ign_wr_cnt", wr_addr.size(), 1);
    if (wr_data.size() == 1) check_eq("ign_data", wr_data[0], 32'hEFBEADDE);
    check_eq("ign_ww", {22'd0, words_written}, 32'd1);
    check_eq("ign_idle", {31'd0, busy}, 32'd0);
    check_eq("ign_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: ADDR_W, default 9, word-address width of the target RAM write port.
REQ-002 Parameter: LEN_W, default 10, width of the word-count fields (must be ADDR_W+1).
REQ-003 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 Port: len_words  input  LEN_W  number of 32-bit words to load; sampled with start.
REQ-007 Port: s_valid  input  1  byte stream valid.
REQ-008 Port: s_data  input  8  byte stream data.
REQ-009 Port: s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-010 Port: ena  output  1  RAM write-port enable.
REQ-011 Port: wea  output  1  RAM write enable; always equal to ena.
REQ-012 Port: addra  output  ADDR_W  RAM write word address.
REQ-013 Port: dina  output  32  RAM write data.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: done  output  1  one-cycle pulse when a load completes.
REQ-016 Port: words_written  output  LEN_W  words written in the current or last load.
REQ-017 Port: checksum  output  32  running sum of written words (see Configuration).

Function
REQ-018 FSM states: IDLE, RECV, WRITE, DONE; all outputs are registered or decoded from state only, with no combinational path from s_valid to s_ready.
REQ-019 IDLE: s_ready=0, ena=0; when start=1, latch len = min(len_words, 2^ADDR_W), clear addr, byte index, words_written and checksum; go to RECV if len!=0, otherwise go to DONE.
REQ-020 start in any state other than IDLE is ignored; len_words is ignored except in the start cycle.
REQ-021 RECV: s_ready=1; each accepted byte is placed little-endian, with byte index k going to word bits [8k+7:8k]; on acceptance of byte index 3, go to WRITE.
REQ-022 RECV with s_valid=0 holds state and the partial word indefinitely.
REQ-023 WRITE lasts exactly one cycle: ena=wea=1, addra=addr, dina=assembled word, s_ready=0.
REQ-024 WRITE exit actions: addr and words_written increment by 1; go to DONE if the new words_written==len, else go to RECV.
REQ-025 DONE lasts exactly one cycle: done=1, then go to IDLE; words_written and checksum hold their values until the next start.
REQ-026 ena=wea=0 in every state except WRITE.
REQ-027 Throughput: minimum 5 cycles per word (4 RECV, 1 WRITE).
REQ-028 Latency: done asserts the cycle after the final WRITE cycle.
REQ-029 addr never wraps within a load, because len is clamped to 2^ADDR_W; a len of 512 writes addresses 0..511.

Reset
REQ-030 rst=1 forces state=IDLE and clears all outputs (s_ready, ena, wea, addra, dina, busy, done, words_written, checksum) to 0, along with the byte index and the partial word.
REQ-031 rst asserted during RECV or WRITE suppresses any write in the reset cycle and discards the partial word; no done pulse is issued.

Configuration
REQ-032 Macro MEM_LOADER_CHECKSUM_EN defined: checksum accumulates dina (mod 2^32) in each WRITE cycle and is cleared on start and on rst.
REQ-033 Macro MEM_LOADER_CHECKSUM_EN undefined: the checksum port remains present and is tied to 32'h0, and no accumulator logic is instantiated.

Verification
REQ-034 Scenario: start, len_words=2, bytes 01 02 03 04 05 06 07 08 with s_valid held high -> writes 32'h04030201 to addr 0 and 32'h08070605 to addr 1; done pulses 11 cycles after start; words_written=2; checksum=32'h0C0A0806 with the macro, 0 without.
REQ-035 Scenario: start with len_words=0 -> no ena pulse; busy high for 1 cycle; done pulses 1 cycle after start; words_written=0.
REQ-036 Scenario: len_words=1 with s_valid toggling every other cycle -> exactly one write of the correct word; s_ready never high while in WRITE or DONE.
REQ-037 Scenario: len_words=700 with 2048 bytes supplied -> exactly 512 writes at addresses 0..511 in order; words_written=512; done pulses.
REQ-038 Scenario: rst asserted after 2 bytes of a word -> no write; outputs 0 next cycle; a new start with len_words=1 writes only the new 4 bytes.
REQ-039 Scenario: start pulsed in RECV with len_words=5 during a len=1 load -> ignored; exactly 1 write occurs.
